// File: rtl/hack_rom_loader_pkg.sv
// Shared widths, error codes and state encodings for the Hack ROM boot loader.
package hack_rom_loader_pkg;

   localparam int WORD_WIDTH    = 16;
   localparam int ADDRESS_WIDTH = 14;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_FRAMING  = 3'd1;
   localparam logic [2:0] ERR_OVERRUN  = 3'd2;
   localparam logic [2:0] ERR_CHECKSUM = 3'd3;
   localparam logic [2:0] ERR_LENGTH   = 3'd4;

   typedef enum logic [3:0] {
      S_START, S_WAIT_INIT, S_CNT_H, S_CNT_L, S_DAT_H, S_DAT_L, S_WRITE,
      S_ACK_HI, S_ACK_LO, S_CS_H, S_CS_L, S_DONE, S_ERROR
   } loader_state_e;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/hack_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle strobes.
module hack_uart_rx
   import hack_rom_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_rx,
   output logic [7:0] o_byte_out,
   output logic       o_byte_strobe,
   output logic       o_frame_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   rx_state_e        r_state, w_state_next;
   logic             r_rx_meta, r_rx_sync, r_rx_prev;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift, r_byte;
   logic             r_strobe, r_frame_err;
   logic             w_fall, w_bit_end, w_half;

   assign w_fall    = r_rx_prev & ~r_rx_sync;
   assign w_bit_end = (r_cnt == LAST);
   assign w_half    = (r_cnt == HALF_LAST);

   // NOTE: next-state logic assigns its default first so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         RX_IDLE:  if (w_fall) w_state_next = RX_START;
         RX_START: if (w_half) w_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_bit_end && r_bit_idx == 3'd7) w_state_next = RX_STOP;
         RX_STOP:  if (w_bit_end) w_state_next = RX_IDLE;
         default:  w_state_next = RX_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= RX_IDLE;
         r_rx_meta   <= 1'b1;
         r_rx_sync   <= 1'b1;
         r_rx_prev   <= 1'b1;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_byte      <= '0;
         r_strobe    <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_meta   <= i_rx;
         r_rx_sync   <= r_rx_meta;
         r_rx_prev   <= r_rx_sync;
         r_state     <= w_state_next;
         r_strobe    <= 1'b0;
         r_frame_err <= 1'b0;
         if (r_state == RX_IDLE || w_state_next != r_state || w_bit_end) r_cnt <= '0;
         else r_cnt <= r_cnt + 1'b1;
         if (r_state == RX_START) r_bit_idx <= '0;
         if (r_state == RX_DATA && w_bit_end) begin
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
         end
         if (r_state == RX_STOP && w_bit_end) begin
            if (r_rx_sync) begin
               r_byte   <= r_shift;
               r_strobe <= 1'b1;
            end else begin
               r_frame_err <= 1'b1;
            end
         end
      end
   end

   assign o_byte_out    = r_byte;
   assign o_byte_strobe = r_strobe;
   assign o_frame_err   = r_frame_err;

endmodule

// File: rtl/hack_rom_loader.sv
// Boot loader: receives count/words/checksum over UART and writes words into ROM
// through the encoder's request/busy port, holding the CPU in reset until done.
module hack_rom_loader
   import hack_rom_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_enable,
   input  logic                     i_uart_rx,
   input  logic                     i_sram_initialized,
   input  logic                     i_sram_busy,
   output logic                     o_sram_request,
   output logic                     o_sram_write_enable,
   output logic [ADDRESS_WIDTH-1:0] o_sram_address,
   output logic [WORD_WIDTH-1:0]    o_sram_wdata,
   output logic                     o_done,
   output logic                     o_error,
   output logic [2:0]               o_error_code,
   output logic [ADDRESS_WIDTH:0]   o_words_loaded,
   output logic                     o_hold_cpu_reset
);

   localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDRESS_WIDTH);

   loader_state_e            r_state, w_state_next;
   logic [7:0]               w_rx_byte, r_rx_byte, r_cs_hi;
   logic                     w_rx_strobe, w_rx_frame_err, r_rx_valid;
   logic [15:0]              r_count, r_csum, w_count_rx, w_cs_rx, w_csum_next;
   logic [WORD_WIDTH-1:0]    r_word;
   logic [ADDRESS_WIDTH:0]   r_words_loaded, w_loaded_next;
   logic                     r_sram_request, r_done, r_error;
   logic [2:0]               r_error_code, w_err_code;
   logic                     w_accept, w_consume, w_request, w_word_ack;

   hack_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
      .clk          (clk),
      .reset        (reset),
      .i_rx         (i_uart_rx),
      .o_byte_out   (w_rx_byte),
      .o_byte_strobe(w_rx_strobe),
      .o_frame_err  (w_rx_frame_err)
   );

   // Bytes are only meaningful once the stream has started and before a terminal state.
   assign w_accept      = !(r_state inside {S_START, S_WAIT_INIT, S_DONE, S_ERROR});
   assign w_count_rx    = {r_count[15:8], r_rx_byte};
   assign w_cs_rx       = {r_cs_hi, r_rx_byte};
   assign w_csum_next   = r_csum + r_word;
   assign w_loaded_next = r_words_loaded + 1'b1;

   always_comb begin
      w_state_next = r_state;
      w_consume    = 1'b0;
      w_request    = 1'b0;
      w_word_ack   = 1'b0;
      w_err_code   = ERR_NONE;
      case (r_state)
         S_START:     w_state_next = i_enable ? S_WAIT_INIT : S_DONE;
         S_WAIT_INIT: if (i_sram_initialized) w_state_next = S_CNT_H;
         S_CNT_H, S_DAT_H, S_DAT_L, S_CS_H: if (r_rx_valid) begin
            w_consume = 1'b1;
            case (r_state)
               S_CNT_H: w_state_next = S_CNT_L;
               S_DAT_H: w_state_next = S_DAT_L;
               S_DAT_L: w_state_next = S_WRITE;
               default: w_state_next = S_CS_L;
            endcase
         end
         S_CNT_L: if (r_rx_valid) begin
            w_consume = 1'b1;
            if ({1'b0, w_count_rx} > MAX_WORDS) begin
               w_state_next = S_ERROR;
               w_err_code   = ERR_LENGTH;
            end else begin
               w_state_next = (w_count_rx == 16'd0) ? S_CS_H : S_DAT_H;
            end
         end
         S_WRITE: if (i_sram_initialized && !i_sram_busy) begin
            w_request    = 1'b1;
            w_state_next = S_ACK_HI;
         end
         S_ACK_HI: if (i_sram_busy) w_state_next = S_ACK_LO;
         S_ACK_LO: if (!i_sram_busy) begin
            w_word_ack   = 1'b1;
            w_state_next = (16'(w_loaded_next) == r_count) ? S_CS_H : S_DAT_H;
         end
         S_CS_L: if (r_rx_valid) begin
            w_consume = 1'b1;
            if (w_cs_rx == r_csum) begin
               w_state_next = S_DONE;
            end else begin
               w_state_next = S_ERROR;
               w_err_code   = ERR_CHECKSUM;
            end
         end
         default: w_state_next = r_state;
      endcase
      // A simultaneous consume frees the hold register, so only an unconsumed byte overruns.
      if (w_accept && w_state_next != S_ERROR &&
          (w_rx_frame_err || (w_rx_strobe && r_rx_valid && !w_consume))) begin
         w_state_next = S_ERROR;
         w_err_code   = w_rx_frame_err ? ERR_FRAMING : ERR_OVERRUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_START;
         r_rx_valid     <= 1'b0;
         r_rx_byte      <= '0;
         r_count        <= '0;
         r_word         <= '0;
         r_cs_hi        <= '0;
         r_csum         <= '0;
         r_words_loaded <= '0;
         r_sram_request <= 1'b0;
         r_done         <= 1'b0;
         r_error        <= 1'b0;
         r_error_code   <= ERR_NONE;
      end else begin
         r_state        <= w_state_next;
         r_sram_request <= w_request;
         if (w_accept && w_rx_strobe) begin
            r_rx_byte  <= w_rx_byte;
            r_rx_valid <= 1'b1;
         end else if (w_consume) begin
            r_rx_valid <= 1'b0;
         end
         if (w_consume) begin
            case (r_state)
               S_CNT_H: r_count[15:8]            <= r_rx_byte;
               S_CNT_L: r_count[7:0]             <= r_rx_byte;
               S_DAT_H: r_word[WORD_WIDTH-1:8]   <= r_rx_byte;
               S_DAT_L: r_word[7:0]              <= r_rx_byte;
               S_CS_H:  r_cs_hi                  <= r_rx_byte;
               default: r_cs_hi                  <= r_cs_hi;
            endcase
         end
         if (w_word_ack) begin
            r_words_loaded <= w_loaded_next;
            r_csum         <= w_csum_next;
         end
         if (r_state == S_DONE) r_done <= 1'b1;
         if (w_err_code != ERR_NONE) begin
            r_error      <= 1'b1;
            r_error_code <= w_err_code;
         end
      end
   end

   assign o_sram_request      = r_sram_request;
   assign o_sram_write_enable = r_sram_request;
   assign o_sram_address      = r_words_loaded[ADDRESS_WIDTH-1:0];
   assign o_sram_wdata        = r_word;
   assign o_done              = r_done;
   assign o_error             = r_error;
   assign o_error_code        = r_error_code;
   assign o_words_loaded      = r_words_loaded;
   assign o_hold_cpu_reset    = ~r_done;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader with a busy-for-6-cycles encoder model.
module tb_hack_rom_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        uart_rx;
   logic        sram_init;
   logic        force_busy;
   logic        sram_busy;
   logic        sram_request, sram_we, done, error, hold_cpu_reset;
   logic [13:0] sram_address;
   logic [15:0] sram_wdata;
   logic [2:0]  error_code;
   logic [14:0] words_loaded;

   int checks = 0;
   int failures = 0;
   int req_count = 0;
   int busy_cnt = 0;
   int we_mismatch = 0;
   int unstable = 0;
   logic [13:0] wr_addr [0:255];
   logic [15:0] wr_data [0:255];
   logic [13:0] last_addr;
   logic [15:0] last_data;

   hack_rom_loader #(.CLKS_PER_BIT(4)) dut (
      .clk                (clk),
      .reset              (reset),
      .i_enable           (enable),
      .i_uart_rx          (uart_rx),
      .i_sram_initialized (sram_init),
      .i_sram_busy        (sram_busy),
      .o_sram_request     (sram_request),
      .o_sram_write_enable(sram_we),
      .o_sram_address     (sram_address),
      .o_sram_wdata       (sram_wdata),
      .o_done             (done),
      .o_error            (error),
      .o_error_code       (error_code),
      .o_words_loaded     (words_loaded),
      .o_hold_cpu_reset   (hold_cpu_reset)
   );

   always #5 clk = ~clk;

   // Encoder model: busy rises the cycle after a request and stays high for 6 cycles.
   always @(posedge clk) begin
      if (sram_we !== sram_request) we_mismatch <= we_mismatch + 1;
      if (sram_request) begin
         if (req_count < 256) begin
            wr_addr[req_count[7:0]] <= sram_address;
            wr_data[req_count[7:0]] <= sram_wdata;
         end
         last_addr <= sram_address;
         last_data <= sram_wdata;
         req_count <= req_count + 1;
         busy_cnt  <= 6;
      end else if (busy_cnt > 0) begin
         if (sram_address !== last_addr || sram_wdata !== last_data) unstable <= unstable + 1;
         busy_cnt <= busy_cnt - 1;
      end
   end
   assign sram_busy = (busy_cnt != 0) || force_busy;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic en);
      reset = 1'b1;
      enable = en;
      uart_rx = 1'b1;
      force_busy = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      repeat (4) tick();
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (4) tick();
      end
      uart_rx = stop_bit;
      repeat (4) tick();
      uart_rx = 1'b1;
      repeat (8) tick();
   endtask

   task automatic wait_end(input string name);
      int n;
      n = 0;
      while (!done && !error && n < 3000) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 3000) begin
         failures++;
         $display("FAIL %s_timeout done=%0b error=%0b after %0d cycles", name, done, error, n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      enable = 1'b1;
      uart_rx = 1'b1;
      sram_init = 1'b1;
      force_busy = 1'b0;
      repeat (3) tick();
      checks++;
      if ({sram_request, sram_we, done, error, hold_cpu_reset} !== 5'b00001) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=00001", {sram_request, sram_we, done, error, hold_cpu_reset});
      end
      checks++;
      if (error_code !== 3'd0 || words_loaded !== 15'd0) begin
         failures++;
         $display("FAIL reset_counts code=%0d words=%0d exp 0/0", error_code, words_loaded);
      end
      checks++;
      if (sram_address !== 14'd0 || sram_wdata !== 16'd0) begin
         failures++;
         $display("FAIL reset_bus addr=%h data=%h exp 0/0", sram_address, sram_wdata);
      end
   endtask

   task automatic test_bypass();
      int base;
      do_reset(1'b0);
      base = req_count;
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL bypass_done_early got=%0b exp=0", done);
      end
      tick();
      checks++;
      if (done !== 1'b1 || hold_cpu_reset !== 1'b0) begin
         failures++;
         $display("FAIL bypass_done got done=%0b hold=%0b exp 1/0", done, hold_cpu_reset);
      end
      repeat (20) tick();
      checks++;
      if (req_count !== base || error !== 1'b0) begin
         failures++;
         $display("FAIL bypass_no_req requests=%0d error=%0b exp 0/0", req_count - base, error);
      end
   endtask

   task automatic test_load_two();
      int base;
      do_reset(1'b1);
      base = req_count;
      send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
      send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
      send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
      send_byte(8'hBE, 1'b1); send_byte(8'h01, 1'b1);
      wait_end("load");
      checks++;
      if (req_count - base !== 2) begin
         failures++;
         $display("FAIL load_requests got=%0d exp=2", req_count - base);
      end
      checks++;
      if (wr_addr[base[7:0]] !== 14'd0 || wr_data[base[7:0]] !== 16'h1234) begin
         failures++;
         $display("FAIL load_write0 got=(%0d,%h) exp=(0,1234)", wr_addr[base[7:0]], wr_data[base[7:0]]);
      end
      checks++;
      if (wr_addr[8'(base + 1)] !== 14'd1 || wr_data[8'(base + 1)] !== 16'hABCD) begin
         failures++;
         $display("FAIL load_write1 got=(%0d,%h) exp=(1,abcd)", wr_addr[8'(base + 1)], wr_data[8'(base + 1)]);
      end
      checks++;
      if (done !== 1'b1 || error !== 1'b0 || hold_cpu_reset !== 1'b0 || words_loaded !== 15'd2) begin
         failures++;
         $display("FAIL load_status done=%0b error=%0b hold=%0b words=%0d exp 1/0/0/2",
                  done, error, hold_cpu_reset, words_loaded);
      end
   endtask

   task automatic test_bad_checksum();
      int base;
      do_reset(1'b1);
      base = req_count;
      send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
      send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
      send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
      send_byte(8'hBE, 1'b1); send_byte(8'h02, 1'b1);
      wait_end("csum");
      checks++;
      if (req_count - base !== 2 || words_loaded !== 15'd2) begin
         failures++;
         $display("FAIL csum_writes requests=%0d words=%0d exp 2/2", req_count - base, words_loaded);
      end
      checks++;
      if (error !== 1'b1 || error_code !== 3'd3 || done !== 1'b0 || hold_cpu_reset !== 1'b1) begin
         failures++;
         $display("FAIL csum_error error=%0b code=%0d done=%0b hold=%0b exp 1/3/0/1",
                  error, error_code, done, hold_cpu_reset);
      end
      checks++;
      if (we_mismatch !== 0 || unstable !== 0) begin
         failures++;
         $display("FAIL write_port we_mismatch=%0d unstable=%0d exp 0/0", we_mismatch, unstable);
      end
   endtask

   task automatic test_length();
      int base;
      do_reset(1'b1);
      base = req_count;
      send_byte(8'h40, 1'b1); send_byte(8'h01, 1'b1);
      checks++;
      if (error !== 1'b1 || error_code !== 3'd4 || req_count !== base) begin
         failures++;
         $display("FAIL length_error error=%0b code=%0d requests=%0d exp 1/4/0",
                  error, error_code, req_count - base);
      end
   endtask

   task automatic test_framing();
      int base;
      do_reset(1'b1);
      base = req_count;
      send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
      send_byte(8'h12, 1'b0);
      checks++;
      if (error !== 1'b1 || error_code !== 3'd1 || req_count !== base) begin
         failures++;
         $display("FAIL framing_error error=%0b code=%0d requests=%0d exp 1/1/0",
                  error, error_code, req_count - base);
      end
   endtask

   task automatic test_overrun();
      do_reset(1'b1);
      send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
      force_busy = 1'b1;
      send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
      send_byte(8'h56, 1'b1); send_byte(8'h78, 1'b1);
      force_busy = 1'b0;
      checks++;
      if (error !== 1'b1 || error_code !== 3'd2 || words_loaded !== 15'd0) begin
         failures++;
         $display("FAIL overrun_error error=%0b code=%0d words=%0d exp 1/2/0", error, error_code, words_loaded);
      end
   endtask

   task automatic test_zero_count();
      int base;
      sram_init = 1'b0;
      do_reset(1'b1);
      base = req_count;
      send_byte(8'h55, 1'b1);
      sram_init = 1'b1;
      send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
      wait_end("zero");
      checks++;
      if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 15'd0 || req_count !== base) begin
         failures++;
         $display("FAIL zero_count done=%0b error=%0b words=%0d requests=%0d exp 1/0/0/0",
                  done, error, words_loaded, req_count - base);
      end
   endtask

   task automatic test_reset_mid_write();
      int base;
      int n;
      do_reset(1'b1);
      base = req_count;
      send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
      send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
      n = 0;
      while (req_count == base && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (req_count == base || wr_data[base[7:0]] !== 16'h1234) begin
         failures++;
         $display("FAIL midwrite_request requests=%0d data=%h exp 1/1234", req_count - base, wr_data[base[7:0]]);
      end
      reset = 1'b1;
      tick();
      checks++;
      if ({sram_request, sram_we, done, error, hold_cpu_reset} !== 5'b00001 ||
          error_code !== 3'd0 || words_loaded !== 15'd0 || sram_wdata !== 16'd0) begin
         failures++;
         $display("FAIL midwrite_reset flags=%b code=%0d words=%0d data=%h exp 00001/0/0/0000",
                  {sram_request, sram_we, done, error, hold_cpu_reset}, error_code, words_loaded, sram_wdata);
      end
      tick();
      reset = 1'b0;
      base = req_count;
      repeat (60) tick();
      checks++;
      if (req_count !== base || words_loaded !== 15'd0 || done !== 1'b0) begin
         failures++;
         $display("FAIL midwrite_after requests=%0d words=%0d done=%0b exp 0/0/0",
                  req_count - base, words_loaded, done);
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_load_two();
      test_bad_checksum();
      test_length();
      test_framing();
      test_overrun();
      test_zero_count();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
